// File: rtl/spi_main_gen.sv
// spi_main_gen: single-frame SPI main (controller) with programmable polarity, phase and chip select
//
// Parameters:
//   DATA_W   frame width in bits (4..32)
//   CLK_DIV  clk cycles per SCLK half-period (>=1)
//   NUM_CS   number of chip selects (1..8)
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous active-high reset
//   start    transfer request, honoured only while idle
//   tx       transmit word, latched on accepted start
//   cs_sel   target select, latched on accepted start
//   cpol     SCLK idle level, latched on accepted start
//   cpha     0: sample leading / shift trailing, 1: shift leading / sample trailing
//   miso     serial data from target
//   sclk     serial clock
//   mosi     serial data to target
//   cs_n     active-low selects, one-hot-low while a valid target is selected
//   rx       last received word, updated when a frame completes
//   busy     high from the cycle after an accepted start through the done cycle
//   done     one-cycle completion pulse
// Build option:
//   SPI_MAIN_GEN_LSB_FIRST_EN  shift tx out and assemble rx LSB first (MSB first otherwise)
module spi_main_gen #(
    parameter int DATA_W = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS = 1,
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output logic [DATA_W-1:0] rx,
    output logic              busy,
    output logic              done
);
`ifdef SPI_MAIN_GEN_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam int EW = $clog2(2 * DATA_W) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);
    localparam logic [EW-1:0] E_LAST = EW'(2 * DATA_W - 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] XFER  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [EW-1:0]     ecnt;
    logic              sclk_r;
    logic              mosi_r;
    logic              cpha_r;
    logic [CS_W-1:0]   cs_sel_r;
    logic [DATA_W-1:0] sh_tx;
    logic [DATA_W-1:0] sh_rx;
    logic [DATA_W-1:0] rx_r;
    logic              sel_act;
    function automatic logic head(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_W-1];
    endfunction
    function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction
    assign sel_act = (state == SETUP) || (state == XFER) || (state == HOLD);
    assign busy    = state != IDLE;
    assign done    = state == DONE;
    assign sclk    = sclk_r;
    assign mosi    = mosi_r;
    assign rx      = rx_r;
    // an out-of-range cs_sel matches no bit, so the frame runs with every select high
    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) cs_n[i] = !(sel_act && cs_sel_r == CS_W'(i));
    end
    // ecnt counts SCLK edges already produced: even = next edge is leading.
    // For cpha=0 the first bit is preloaded on mosi during SETUP, so both phases
    // share one "present next bit" operation on their advancing edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ecnt     <= '0;
            sclk_r   <= 1'b0;
            mosi_r   <= 1'b0;
            cpha_r   <= 1'b0;
            cs_sel_r <= '0;
            sh_tx    <= '0;
            sh_rx    <= '0;
            rx_r     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= SETUP;
                    cnt      <= '0;
                    ecnt     <= '0;
                    sclk_r   <= cpol;
                    cpha_r   <= cpha;
                    cs_sel_r <= cs_sel;
                    sh_tx    <= cpha ? tx : adv(tx);
                    mosi_r   <= cpha ? 1'b0 : head(tx);
                end
                SETUP: begin
                    cnt   <= (cnt == C_LAST) ? '0 : cnt + 1'b1;
                    state <= (cnt == C_LAST) ? XFER : SETUP;
                end
                XFER: begin
                    if (cnt == C_LAST) begin
                        cnt    <= '0;
                        ecnt   <= ecnt + 1'b1;
                        sclk_r <= ~sclk_r;
                        if (ecnt[0] != cpha_r) begin
                            mosi_r <= head(sh_tx);
                            sh_tx  <= adv(sh_tx);
                        end else begin
                            sh_rx <= LSB_FIRST ? {miso, sh_rx[DATA_W-1:1]} : {sh_rx[DATA_W-2:0], miso};
                        end
                        if (ecnt == E_LAST) state <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == C_LAST) begin
                        cnt    <= '0;
                        state  <= DONE;
                        rx_r   <= sh_rx;
                        mosi_r <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ecnt  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_main_gen.sv
// tb_spi_main_gen: randomized self-checking bench for spi_main_gen with a behavioural SPI target
module tb_spi_main_gen;
    localparam int W = 8;
    localparam int C = 2;
    localparam int NCS = 3;
    localparam int D = 1 + C * (2 * W + 2);
`ifdef SPI_MAIN_GEN_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, start, cpol, cpha, miso, sclk, mosi, busy, done;
    logic [W-1:0] tx, rx;
    logic [1:0] cs_sel;
    logic [NCS-1:0] cs_n;
    logic loop_en = 1'b0;
    logic miso_drv = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    assign miso = loop_en ? mosi : miso_drv;
    always #5 clk = ~clk;
    spi_main_gen #(.DATA_W(W), .CLK_DIV(C), .NUM_CS(NCS)) dut (
        .clk(clk), .rst(rst), .start(start), .tx(tx), .cs_sel(cs_sel), .cpol(cpol),
        .cpha(cpha), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .rx(rx),
        .busy(busy), .done(done)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic rbit(input logic [W-1:0] r, input int i);
        if (i >= W) return 1'b0;
        return LSB ? r[i] : r[W-1-i];
    endfunction
    task automatic scramble();
        tx = W'($urandom);
        cs_sel = 2'($urandom);
        cpol = 1'($urandom);
        cpha = 1'($urandom);
    endtask
    // One frame from start to the done cycle; the target serves 'reply' bit by bit
    // and collects mosi on the sampling edges the mode defines.
    task automatic frame(input logic [W-1:0] t, input logic [1:0] s, input logic p, input logic h,
                         input logic lp, input logic [W-1:0] reply, input int rep_at);
        logic [W-1:0] word, rx0, exp_rx;
        logic [NCS-1:0] exp_cs;
        logic prev, cur, lead;
        int edges, rises, ti;
        word = '0; edges = 0; rises = 0; ti = 0;
        @(negedge clk);
        start = 1'b1; tx = t; cs_sel = s; cpol = p; cpha = h; loop_en = lp;
        rx0 = rx;
        exp_rx = lp ? t : reply;
        if (!h) begin
            miso_drv = rbit(reply, 0);
            ti = 1;
        end
        prev = p;
        @(posedge clk);
        #1 start = 1'b0;
        scramble();
        for (int c = 1; c <= D; c++) begin
            @(negedge clk);
            exp_cs = (c < D && s < NCS) ? ~(NCS'(1) << s) : '1;
            chk("cs_n", 32'(cs_n), 32'(exp_cs));
            chk("busy", 32'(busy), 32'd1);
            chk("done", 32'(done), 32'(c == D));
            cur = sclk;
            if (c == 1) begin
                chk("sclk_setup", 32'(sclk), 32'(p));
                if (!h) chk("mosi_setup", 32'(mosi), 32'(rbit(t, 0)));
            end
            if (cur !== prev) begin
                edges++;
                if (cur) rises++;
                lead = (prev == p);
                if (lead != h) word = LSB ? {mosi, word[W-1:1]} : {word[W-2:0], mosi};
                else begin
                    miso_drv = rbit(reply, ti);
                    ti++;
                end
            end
            prev = cur;
            if (c < D) chk("rx_hold", 32'(rx), 32'(rx0));
            else begin
                chk("rx", 32'(rx), 32'(exp_rx));
                chk("mosi_done", 32'(mosi), 32'd0);
                chk("edges", edges, 2 * W);
                chk("rises", rises, W);
                chk("mosi_word", 32'(word), 32'(t));
                chk("sclk_idle", 32'(sclk), 32'(p));
            end
            if (c == rep_at) begin
                start = 1'b1;
                tx = W'($urandom);
            end else start = 1'b0;
        end
    endtask
    task automatic rst_mid();
        int seen;
        seen = 0;
        @(negedge clk);
        start = 1'b1; tx = W'($urandom); cs_sel = 2'd0; cpol = 1'b1; cpha = 1'b0; loop_en = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        chk("busy_mid", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'h7);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx", 32'(rx), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("no_done_after_abort", seen, 0);
        chk("idle_after_abort", 32'(busy), 32'd0);
    endtask
    initial begin
        rst = 1'b1; start = 1'b1; tx = 8'hFF; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cs_n", 32'(cs_n), 32'h7);
        chk("reset_sclk", 32'(sclk), 32'd0);
        chk("reset_mosi", 32'(mosi), 32'd0);
        chk("reset_rx", 32'(rx), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start_during_rst", 32'(busy), 32'd0);
        frame(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 0);
        frame(8'h3C, 2'd1, 1'b1, 1'b1, 1'b0, 8'hC3, 0);
        frame(8'h5A, 2'd2, 1'b0, 1'b1, 1'b0, 8'h96, 10);
        frame(8'h69, 2'd2, 1'b1, 1'b0, 1'b0, 8'h0F, 0);
        frame(8'h81, 2'd3, 1'b0, 1'b0, 1'b1, 8'h00, 0);
        frame(8'h01, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 0);
        rst_mid();
        for (int k = 0; k < 16; k++)
            frame(W'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  1'($urandom), W'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0);
        @(negedge clk);
        chk("final_idle", 32'(busy), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
